// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The entry type is sized for the widest supported PC/instruction; narrower builds zero-extend.
package fetch_pkg;

    localparam int CNT_W       = 32;
    localparam int FETCH_WIDTH = 32;
    localparam int FETCH_ILEN  = 32;

    localparam logic [FETCH_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [FETCH_WIDTH-1:0] DEFAULT_PC_STEP  = 32'd4;

    typedef struct packed {
        logic [FETCH_ILEN-1:0]  instr;
        logic [FETCH_WIDTH-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of PC-tagged instructions; flush takes priority over push.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_q, wr_d;
    logic [AW-1:0]  rd_q, rd_d;
    logic [AW:0]    count_q, count_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push) wr_d = wr_q + AW'(1);
            if (pop)  rd_d = rd_q + AW'(1);
            count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the top masks the head whenever count is zero.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_q] <= push_data;
    end

    assign head  = mem_q[rd_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with credit-based prefetch FIFO and redirect flush.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = FETCH_WIDTH,
    parameter int               ILEN     = FETCH_ILEN,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC[WIDTH-1:0],
    parameter logic [WIDTH-1:0] PC_STEP  = DEFAULT_PC_STEP[WIDTH-1:0]
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_base,
    input  logic [WIDTH-1:0] redirect_imm,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [ILEN-1:0]  imem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ILEN-1:0]  out_instr,
    output logic [WIDTH-1:0] out_pc
`ifdef FETCH_PERF_EN
   ,output logic [CNT_W-1:0] perf_fetched,
    output logic [CNT_W-1:0] perf_stall,
    output logic [CNT_W-1:0] perf_flush
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic             inflight_q, drop_q;
    logic [AW:0]      count;
    logic [AW+1:0]    credit;
    logic             push, pop, starved;
    fetch_entry_t     head, push_data;

    // Credit is taken from the registered count, so a pop frees a slot only next cycle.
    assign credit   = {1'b0, count} + {{(AW+1){1'b0}}, inflight_q};
    assign starved  = credit >= (AW+2)'(DEPTH);
    assign imem_req = rst && !redirect && !starved;
    assign imem_addr = pc_q;

    always_comb begin
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        if (redirect) begin
            pc_d = redirect_base + redirect_imm;
        end else if (imem_req) begin
            pc_d      = pc_q + PC_STEP;
            resp_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= imem_req;
            drop_q     <= redirect && inflight_q;
        end
    end

    assign push      = inflight_q && !drop_q;
    assign pop       = out_valid && out_ready;
    assign push_data = '{instr: FETCH_ILEN'(imem_rdata), pc: FETCH_WIDTH'(resp_pc_q)};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .count     (count)
    );

    assign out_valid = (count != '0);
    assign out_instr = out_valid ? head.instr[ILEN-1:0] : '0;
    assign out_pc    = out_valid ? head.pc[WIDTH-1:0]   : '0;

`ifdef FETCH_PERF_EN
    logic [CNT_W-1:0] fetched_q, stall_q, flush_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetched_q <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            if (push)                  fetched_q <= fetched_q + CNT_W'(1);
            if (starved && !redirect)  stall_q   <= stall_q + CNT_W'(1);
            if (redirect)              flush_q   <= flush_q + CNT_W'(1);
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stall   = stall_q;
    assign perf_flush   = flush_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a 32-bit default instance and a 16-bit wrap-around instance.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        redirect;
    logic [31:0] redirect_base, redirect_imm;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_pc;

    logic        redir16, rdy16;
    logic [15:0] base16, imm16;
    logic        imem_req16;
    logic [15:0] imem_addr16;
    logic [31:0] rdata16;
    logic        out_valid16;
    logic [31:0] out_instr16;
    logic [15:0] out_pc16;

`ifdef FETCH_PERF_EN
    logic [CNT_W-1:0] pf_fetched, pf_stall, pf_flush;
    logic [CNT_W-1:0] pf16_fetched, pf16_stall, pf16_flush;
`endif

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .redirect      (redirect),
        .redirect_base (redirect_base),
        .redirect_imm  (redirect_imm),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc)
`ifdef FETCH_PERF_EN
       ,.perf_fetched  (pf_fetched),
        .perf_stall    (pf_stall),
        .perf_flush    (pf_flush)
`endif
    );

    fetch_unit #(
        .WIDTH    (16),
        .RESET_PC (16'hFFF8),
        .PC_STEP  (16'd4)
    ) dut16 (
        .clk           (clk),
        .rst           (rst),
        .redirect      (redir16),
        .redirect_base (base16),
        .redirect_imm  (imm16),
        .imem_req      (imem_req16),
        .imem_addr     (imem_addr16),
        .imem_rdata    (rdata16),
        .out_valid     (out_valid16),
        .out_ready     (rdy16),
        .out_instr     (out_instr16),
        .out_pc        (out_pc16)
`ifdef FETCH_PERF_EN
       ,.perf_fetched  (pf16_fetched),
        .perf_stall    (pf16_stall),
        .perf_flush    (pf16_flush)
`endif
    );

    // Synchronous memories with one-cycle latency; each word holds its own index.
    always @(posedge clk) if (imem_req)   imem_rdata <= {2'b00, imem_addr[31:2]};
    always @(posedge clk) if (imem_req16) rdata16    <= {18'd0, imem_addr16[15:2]};

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb16_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        logic [31:0] pc;
        sb_q.delete();
        for (int i = 0; i < n; i++) begin
            pc = start + 32'(4 * i);
            sb_q.push_back('{pc: pc, instr: pc >> 2});
        end
    endtask

    task automatic expect_seq16(input logic [15:0] start, input int n);
        logic [15:0] pc;
        sb16_q.delete();
        for (int i = 0; i < n; i++) begin
            pc = start + 16'(4 * i);
            sb16_q.push_back('{pc: 32'(pc), instr: 32'(pc >> 2)});
        end
    endtask

    // One cycle: drive at the falling edge, settle, then score any handshake.
    task automatic cyc(input logic rst_v, input logic rdy, input logic redir,
                       input logic [31:0] base, input logic [31:0] imm);
        exp_t e;
        @(negedge clk);
        rst           = rst_v;
        out_ready     = rdy;
        redirect      = redir;
        redirect_base = base;
        redirect_imm  = imm;
        #1;
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out", 64'(out_valid), 64'(0));
            end else begin
                e = sb_q.pop_front();
                check("out_pc", 64'(out_pc), 64'(e.pc));
                check("out_instr", 64'(out_instr), 64'(e.instr));
            end
        end
        if (out_valid16 && rdy16) begin
            if (sb16_q.size() == 0) begin
                check("unexpected_out16", 64'(out_valid16), 64'(0));
            end else begin
                e = sb16_q.pop_front();
                check("out_pc16", 64'(out_pc16), 64'(e.pc));
                check("out_instr16", 64'(out_instr16), 64'(e.instr));
            end
        end
    endtask

    task automatic redir_check(input logic rdy_t, input logic [31:0] base, input logic [31:0] imm);
        cyc(1'b1, rdy_t, 1'b1, base, imm);
        check("redir_req_off", 64'(imem_req), 64'(0));
        expect_seq(base + imm, 64);
        cyc(1'b1, 1'b1, 1'b0, '0, '0);
        check("tgt_req", 64'(imem_req), 64'(1));
        check("tgt_addr", 64'(imem_addr), 64'(base + imm));
        check("tgt_gap1", 64'(out_valid), 64'(0));
        cyc(1'b1, 1'b1, 1'b0, '0, '0);
        check("tgt_gap2", 64'(out_valid), 64'(0));
        cyc(1'b1, 1'b1, 1'b0, '0, '0);
        check("tgt_valid", 64'(out_valid), 64'(1));
    endtask

    initial begin
        rst = 1'b0; out_ready = 1'b0; redirect = 1'b0;
        redirect_base = '0; redirect_imm = '0;
        redir16 = 1'b0; rdy16 = 1'b0; base16 = '0; imm16 = '0;

        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, '0, '0);
        check("rst_req", 64'(imem_req), 64'(0));
        check("rst_addr", 64'(imem_addr), 64'(0));
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_instr", 64'(out_instr), 64'(0));
        check("rst_pc", 64'(out_pc), 64'(0));
        check("rst_addr16", 64'(imem_addr16), 64'(16'hFFF8));
        check("rst_req16", 64'(imem_req16), 64'(0));

        // Release: first request immediately, first instruction two cycles later.
        rdy16 = 1'b1;
        expect_seq(32'h0, 64);
        expect_seq16(16'hFFF8, 64);
        cyc(1'b1, 1'b1, 1'b0, '0, '0);
        check("first_req", 64'(imem_req), 64'(1));
        check("first_addr", 64'(imem_addr), 64'(0));
        check("first_gap0", 64'(out_valid), 64'(0));
        cyc(1'b1, 1'b1, 1'b0, '0, '0);
        check("first_gap1", 64'(out_valid), 64'(0));
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 1'b0, '0, '0);
            check("stream_valid", 64'(out_valid), 64'(1));
        end

        // Backpressure: FIFO fills to DEPTH and holds its head.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 1'b0, '0, '0);
            check("hold_valid", 64'(out_valid), 64'(1));
            check("hold_pc", 64'(out_pc), 64'(sb_q[0].pc));
        end
        check("full_req", 64'(imem_req), 64'(0));
        check("full_addr", 64'(imem_addr), 64'(32'd32));
        cyc(1'b1, 1'b1, 1'b0, '0, '0);
        check("rel_req", 64'(imem_req), 64'(0));
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, 1'b0, '0, '0);
            check("rel_valid", 64'(out_valid), 64'(1));
        end

        // Redirect with a response in flight and a non-empty FIFO, no handshake.
        redir_check(1'b0, 32'h20, 32'h40);
        cyc(1'b1, 1'b1, 1'b0, '0, '0);
        cyc(1'b1, 1'b1, 1'b0, '0, '0);

        // Redirect coinciding with handshakes, including the one on pc 8.
        redir_check(1'b1, 32'h0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, '0, '0);
        redir_check(1'b1, 32'h100, 32'h10);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, '0, '0);

        // Back-to-back redirects: the later one wins. The 16-bit instance wraps its target to 0.
        redir16 = 1'b1; base16 = 16'h0004; imm16 = 16'hFFFC;
        cyc(1'b1, 1'b0, 1'b1, 32'h200, 32'h0);
        sb_q.delete();
        redir16 = 1'b0; base16 = '0; imm16 = '0;
        expect_seq16(16'h0000, 64);
        redir_check(1'b1, 32'h300, 32'h4);
        check("w16_valid", 64'(out_valid16), 64'(1));
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, '0, '0);

        // Single-cycle reset mid-stream.
        cyc(1'b0, 1'b1, 1'b0, '0, '0);
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_pc", 64'(out_pc), 64'(0));
        check("mid_rst_req", 64'(imem_req), 64'(0));
        check("mid_rst_valid16", 64'(out_valid16), 64'(0));
`ifdef FETCH_PERF_EN
        check("perf_fetched_rst", 64'(pf_fetched), 64'(0));
        check("perf_stall_rst", 64'(pf_stall), 64'(0));
        check("perf_flush_rst", 64'(pf_flush), 64'(0));
`endif
        sb_q.delete();
        sb16_q.delete();
        expect_seq(32'h0, 64);
        expect_seq16(16'hFFF8, 64);
        cyc(1'b1, 1'b1, 1'b0, '0, '0);
        check("restart_req", 64'(imem_req), 64'(1));
        check("restart_addr", 64'(imem_addr), 64'(0));
        cyc(1'b1, 1'b1, 1'b0, '0, '0);
        check("restart_gap", 64'(out_valid), 64'(0));
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 1'b0, '0, '0);
            check("restart_valid", 64'(out_valid), 64'(1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
